// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: mnemonic codes, RI field layout
// and the fetch FSM state encoding.
package fetch_pkg;

    localparam logic [1:0] MNM_LDR   = 2'b00;
    localparam logic [1:0] MNM_LOGIC = 2'b01;
    localparam logic [1:0] MNM_ADD   = 2'b10;
    localparam logic [1:0] MNM_SUB   = 2'b11;

    localparam int unsigned MNM_HI = 7;
    localparam int unsigned MNM_LO = 6;
    localparam int unsigned RD_HI  = 5;
    localparam int unsigned RD_LO  = 4;
    localparam int unsigned IMM_HI = 3;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHoldPc,
        StHoldRi
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Control-FSM handshake, instruction-memory bus and decoded-field outputs of the fetch stage.
// The fetch unit connects through the master modport; the environment uses slave.
interface fetch_if #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 8
);
    logic               ena_pc;
    logic               ena_ri;
    logic               pc_ack;
    logic               ri_ack;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_data;
    logic               mem_valid;
    logic [1:0]         mnm_out;
    logic [1:0]         rd_out;
    logic [3:0]         imm_out;
    logic [ADDR_W-1:0]  pc_out;

    modport master (
        input  ena_pc, ena_ri, mem_data, mem_valid,
        output pc_ack, ri_ack, mem_req, mem_addr, mnm_out, rd_out, imm_out, pc_out
    );

    modport slave (
        output ena_pc, ena_ri, mem_data, mem_valid,
        input  pc_ack, ri_ack, mem_req, mem_addr, mnm_out, rd_out, imm_out, pc_out
    );
endinterface

// File: rtl/instr_decode.sv
// Purely combinational split of an 8-bit instruction into mnemonic, register and immediate.
// Shared with the datapath so both sides agree on the field layout.
module instr_decode
    import fetch_pkg::*;
(
    input  logic [7:0] instr_i,
    output logic [1:0] mnm_o,
    output logic [1:0] rd_o,
    output logic [3:0] imm_o
);

    assign mnm_o = instr_i[MNM_HI:MNM_LO];
    assign rd_o  = instr_i[RD_HI:RD_LO];
    assign imm_o = instr_i[IMM_HI:IMM_LO];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and RI, serves ena_pc/ena_ri with one-cycle acks and
// reads instructions over a req/valid memory handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 4,
    parameter int unsigned       INSTR_W = 8,
    parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ri_q, ri_d;
    logic               pc_ack_q, pc_ack_d;
    logic               ri_ack_q, ri_ack_d;
    logic               mem_req_q, mem_req_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ri_d      = ri_q;
        pc_ack_d  = 1'b0;
        ri_ack_d  = 1'b0;
        mem_req_d = mem_req_q;
        case (state_q)
            StIdle: begin
                // A fetch request takes priority; PC stays put in that case.
                if (bus.ena_ri) begin
                    state_d   = StFetch;
                    mem_req_d = 1'b1;
                end else if (bus.ena_pc) begin
                    pc_d     = pc_q + ADDR_W'(1);
                    pc_ack_d = 1'b1;
                    state_d  = StHoldPc;
                end
            end
            StFetch: begin
                if (bus.mem_valid) begin
                    ri_d      = bus.mem_data;
                    ri_ack_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StHoldRi;
                end
            end
            // Wait for the acked enable to drop so it cannot re-trigger.
            StHoldPc: if (!bus.ena_pc) state_d = StIdle;
            StHoldRi: if (!bus.ena_ri) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= RST_PC;
            ri_q      <= '0;
            pc_ack_q  <= 1'b0;
            ri_ack_q  <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ri_q      <= ri_d;
            pc_ack_q  <= pc_ack_d;
            ri_ack_q  <= ri_ack_d;
            mem_req_q <= mem_req_d;
        end
    end

    instr_decode u_instr_decode (
        .instr_i (ri_q),
        .mnm_o   (bus.mnm_out),
        .rd_o    (bus.rd_out),
        .imm_o   (bus.imm_out)
    );

    assign bus.pc_ack   = pc_ack_q;
    assign bus.ri_ack   = ri_ack_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = pc_q;
    assign bus.pc_out   = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: acts as control FSM and instruction memory, and
// compares against a PC/RI reference model kept as plain integers.
module tb_fetch_unit;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 8;
    localparam logic [3:0]  RST_PC0 = 4'd0;
    localparam logic [3:0]  RST_PC1 = 4'd15;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    int   m_pc;
    int   m_ri;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus0 ();
    fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus1 ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RST_PC(RST_PC0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RST_PC(RST_PC1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Expected {mnm, rd, imm} of an instruction byte, by plain arithmetic.
    function automatic logic [7:0] exp_fields(input int ri);
        int mnm, rd, imm;
        mnm = ri / 64;
        rd  = (ri / 16) % 4;
        imm = ri % 16;
        return {2'(mnm), 2'(rd), 4'(imm)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus0.ena_pc = 1'b0; bus0.ena_ri = 1'b0; bus0.mem_valid = 1'b0; bus0.mem_data = '0;
        bus1.ena_pc = 1'b0; bus1.ena_ri = 1'b0; bus1.mem_valid = 1'b0; bus1.mem_data = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        m_pc = int'(RST_PC0);
        m_ri = 0;
    endtask

    // Memory model: answers the lat-th cycle of mem_req with data; returns what it saw.
    task automatic do_fetch(input int lat, input logic [7:0] data, output logic [3:0] addr,
                            output int req_cycles, output int ack_cnt,
                            output logic [7:0] fields, output int overlap);
        int waited, post;
        bit seen;
        waited = 0; post = 0; seen = 0;
        req_cycles = 0; ack_cnt = 0; overlap = 0; addr = 'x; fields = 'x;
        bus0.ena_ri = 1'b1;
        for (int c = 0; c < lat + 16; c++) begin
            step();
            if (bus0.ri_ack && bus0.pc_ack) overlap++;
            if (bus0.ri_ack) begin
                ack_cnt++;
                if (!seen) fields = {bus0.mnm_out, bus0.rd_out, bus0.imm_out};
                seen = 1;
                bus0.ena_ri = 1'b0;
            end
            if (bus0.mem_req) begin
                req_cycles++;
                addr = bus0.mem_addr;
                bus0.mem_valid = (waited == lat);
                bus0.mem_data  = (waited == lat) ? data : 8'($urandom);
                waited++;
            end else begin
                bus0.mem_valid = 1'b0;
            end
            if (seen) post++;
            if (post > 3) break;
        end
        bus0.ena_ri = 1'b0;
        bus0.mem_valid = 1'b0;
    endtask

    // Holds ena_pc until the ack, plus `extra` cycles into the hold state.
    task automatic do_pc(input int extra, output int ack_cnt, output logic [3:0] pc_after,
                         output logic [3:0] pc_end, output int overlap);
        int hold;
        bit seen;
        hold = 0; seen = 0; ack_cnt = 0; overlap = 0; pc_after = 'x;
        bus0.ena_pc = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            if (bus0.pc_ack && bus0.ri_ack) overlap++;
            if (bus0.pc_ack) begin
                ack_cnt++;
                if (!seen) pc_after = bus0.pc_out;
                seen = 1;
            end
            if (seen) begin
                if (hold == extra) bus0.ena_pc = 1'b0;
                hold++;
                if (hold > extra + 3) break;
            end
        end
        bus0.ena_pc = 1'b0;
        pc_end = bus0.pc_out;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #12;
        vectors++;
        if ({bus0.pc_ack, bus0.ri_ack, bus0.mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000", {bus0.pc_ack, bus0.ri_ack, bus0.mem_req});
        end
        vectors++;
        if (bus0.pc_out !== RST_PC0) begin
            errors++;
            $display("FAIL reset_pc0: got %0d want %0d", bus0.pc_out, RST_PC0);
        end
        vectors++;
        if ({bus0.mnm_out, bus0.rd_out, bus0.imm_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ri: got %h want 00", {bus0.mnm_out, bus0.rd_out, bus0.imm_out});
        end
        vectors++;
        if (bus1.pc_out !== RST_PC1) begin
            errors++;
            $display("FAIL reset_pc1: got %0d want %0d", bus1.pc_out, RST_PC1);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        m_pc = int'(RST_PC0);
        m_ri = 0;
    endtask

    task automatic test_fetch_basic();
        logic [3:0] addr;
        logic [7:0] fields;
        int req_cycles, ack_cnt, overlap;
        do_fetch(3, 8'hA7, addr, req_cycles, ack_cnt, fields, overlap);
        m_ri = 'hA7;
        vectors++;
        if (addr !== 4'(m_pc)) begin
            errors++; $display("FAIL basic_addr: got %0d want %0d", addr, m_pc);
        end
        vectors++;
        if (req_cycles != 4) begin
            errors++; $display("FAIL basic_req_len: got %0d want 4", req_cycles);
        end
        vectors++;
        if (ack_cnt != 1) begin
            errors++; $display("FAIL basic_ack_cnt: got %0d want 1", ack_cnt);
        end
        vectors++;
        if (fields !== exp_fields(m_ri)) begin
            errors++; $display("FAIL basic_fields: got %h want %h", fields, exp_fields(m_ri));
        end
        vectors++;
        if (bus0.pc_out !== 4'(m_pc)) begin
            errors++; $display("FAIL basic_pc_hold: got %0d want %0d", bus0.pc_out, m_pc);
        end
    endtask

    task automatic test_pc_wrap();
        int acks, hold;
        logic [3:0] pc_seen;
        do_reset();
        acks = 0; hold = 0; pc_seen = 'x;
        bus1.ena_pc = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus1.pc_ack) begin
                acks++;
                pc_seen = bus1.pc_out;
            end
            // Keep ena_pc high one cycle past the ack edge to probe re-triggering.
            if (acks > 0) begin
                if (hold == 1) bus1.ena_pc = 1'b0;
                hold++;
            end
        end
        bus1.ena_pc = 1'b0;
        vectors++;
        if (acks != 1) begin
            errors++; $display("FAIL wrap_ack_cnt: got %0d want 1", acks);
        end
        vectors++;
        if (pc_seen !== 4'((int'(RST_PC1) + 1) % 16)) begin
            errors++; $display("FAIL wrap_pc_at_ack: got %0d want 0", pc_seen);
        end
        vectors++;
        if (bus1.pc_out !== 4'((int'(RST_PC1) + 1) % 16)) begin
            errors++; $display("FAIL wrap_pc_final: got %0d want 0", bus1.pc_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [3];
        int exp_addr [3];
        int exp_mnm [3];
        logic [3:0] addr, pa, pe;
        logic [7:0] fields;
        int req_cycles, ack_cnt, overlap, pack;
        data = '{8'h00, 8'h52, 8'hF3};
        exp_addr = '{1, 2, 3};
        exp_mnm = '{0, 1, 3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_pc(0, pack, pa, pe, overlap);
            m_pc = (m_pc + 1) % 16;
            do_fetch(0, data[i], addr, req_cycles, ack_cnt, fields, overlap);
            m_ri = int'(data[i]);
            vectors++;
            if (pack != 1 || ack_cnt != 1) begin
                errors++;
                $display("FAIL b2b_acks[%0d]: got pc %0d ri %0d want 1 1", i, pack, ack_cnt);
            end
            vectors++;
            if (addr !== 4'(exp_addr[i])) begin
                errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, addr, exp_addr[i]);
            end
            vectors++;
            if (fields[7:6] !== 2'(exp_mnm[i]) || fields !== exp_fields(m_ri)) begin
                errors++;
                $display("FAIL b2b_fields[%0d]: got %h want %h", i, fields, exp_fields(m_ri));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        d = 8'($urandom);
        bus0.ena_pc = 1'b1;
        bus0.ena_ri = 1'b1;
        step();
        vectors++;
        if ({bus0.mem_req, bus0.pc_ack} !== 2'b10 || bus0.mem_addr !== 4'(m_pc)
            || bus0.pc_out !== 4'(m_pc)) begin
            errors++;
            $display("FAIL simul_start: got req %b ack %b addr %0d pc %0d want 1 0 %0d %0d",
                     bus0.mem_req, bus0.pc_ack, bus0.mem_addr, bus0.pc_out, m_pc, m_pc);
        end
        bus0.mem_valid = 1'b1;
        bus0.mem_data  = d;
        step();
        m_ri = int'(d);
        vectors++;
        if ({bus0.ri_ack, bus0.pc_ack} !== 2'b10
            || {bus0.mnm_out, bus0.rd_out, bus0.imm_out} !== exp_fields(m_ri)) begin
            errors++;
            $display("FAIL simul_ri_ack: got ri %b pc %b fields %h want 1 0 %h", bus0.ri_ack,
                     bus0.pc_ack, {bus0.mnm_out, bus0.rd_out, bus0.imm_out}, exp_fields(m_ri));
        end
        bus0.ena_ri = 1'b0;
        bus0.mem_valid = 1'b0;
        step();
        vectors++;
        if ({bus0.ri_ack, bus0.pc_ack} !== 2'b00) begin
            errors++;
            $display("FAIL simul_gap: got ri %b pc %b want 0 0", bus0.ri_ack, bus0.pc_ack);
        end
        step();
        m_pc = (m_pc + 1) % 16;
        vectors++;
        if (bus0.pc_ack !== 1'b1 || bus0.pc_out !== 4'(m_pc)) begin
            errors++;
            $display("FAIL simul_pc_after: got ack %b pc %0d want 1 %0d", bus0.pc_ack,
                     bus0.pc_out, m_pc);
        end
        bus0.ena_pc = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_spurious_valid();
        int acks, reqs;
        acks = 0; reqs = 0;
        for (int c = 0; c < 4; c++) begin
            bus0.mem_valid = 1'b1;
            bus0.mem_data  = ~8'(m_ri);
            step();
            acks += int'(bus0.ri_ack);
            reqs += int'(bus0.mem_req);
        end
        bus0.mem_valid = 1'b0;
        vectors++;
        if (acks != 0 || reqs != 0) begin
            errors++; $display("FAIL spurious_ack: got acks %0d reqs %0d want 0 0", acks, reqs);
        end
        vectors++;
        if ({bus0.mnm_out, bus0.rd_out, bus0.imm_out} !== exp_fields(m_ri)) begin
            errors++;
            $display("FAIL spurious_ri: got %h want %h",
                     {bus0.mnm_out, bus0.rd_out, bus0.imm_out}, exp_fields(m_ri));
        end
    endtask

    task automatic test_async_reset();
        bus0.ena_ri = 1'b1;
        step();
        vectors++;
        if (bus0.mem_req !== 1'b1) begin
            errors++; $display("FAIL areset_pre_req: got %b want 1", bus0.mem_req);
        end
        step();
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus0.mem_req, bus0.ri_ack, bus0.pc_ack} !== 3'b000) begin
            errors++;
            $display("FAIL areset_ctrl: got %b want 000", {bus0.mem_req, bus0.ri_ack, bus0.pc_ack});
        end
        vectors++;
        if (bus0.pc_out !== RST_PC0
            || {bus0.mnm_out, bus0.rd_out, bus0.imm_out} !== 8'h00) begin
            errors++;
            $display("FAIL areset_state: got pc %0d ri %h want %0d 00", bus0.pc_out,
                     {bus0.mnm_out, bus0.rd_out, bus0.imm_out}, RST_PC0);
        end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        step();
        m_pc = int'(RST_PC0);
        m_ri = 0;
    endtask

    task automatic test_random();
        logic [3:0] addr, pa, pe;
        logic [7:0] fields, d;
        int req_cycles, ack_cnt, overlap, lat, extra;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                extra = int'($urandom_range(2, 0));
                do_pc(extra, ack_cnt, pa, pe, overlap);
                m_pc = (m_pc + 1) % 16;
                vectors++;
                if (ack_cnt != 1 || overlap != 0 || pa !== 4'(m_pc) || pe !== 4'(m_pc)
                    || {bus0.mnm_out, bus0.rd_out, bus0.imm_out} !== exp_fields(m_ri)) begin
                    errors++;
                    $display("FAIL rand_pc[%0d]: got acks %0d ovl %0d pc %0d/%0d want 1 0 %0d",
                             i, ack_cnt, overlap, pa, pe, m_pc);
                end
            end else begin
                lat = int'($urandom_range(4, 0));
                d = 8'($urandom);
                do_fetch(lat, d, addr, req_cycles, ack_cnt, fields, overlap);
                m_ri = int'(d);
                vectors++;
                if (addr !== 4'(m_pc) || req_cycles != lat + 1 || ack_cnt != 1 || overlap != 0
                    || fields !== exp_fields(m_ri) || bus0.pc_out !== 4'(m_pc)) begin
                    errors++;
                    $display("FAIL rand_fetch[%0d]: got addr %0d req %0d ack %0d f %h want %0d %0d 1 %h",
                             i, addr, req_cycles, ack_cnt, fields, m_pc, lat + 1,
                             exp_fields(m_ri));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_pc_wrap();
        test_back_to_back();
        test_simultaneous();
        test_spurious_valid();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
